// File: rtl/sgdma_pkg.sv
// rtl/sgdma_pkg.sv - shared state encoding and DataMover command/status field positions
package sgdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // MM2S command fields; address starts at bit 32, tag sits directly above it.
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_ADDR_LSB = 32;

  localparam logic TYPE_INCR = 1'b1;
  localparam logic CMD_EOF   = 1'b1;

  // MM2S status byte
  localparam int STS_TAG_MSB    = 3;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

endpackage

// File: rtl/sgdma_desc_ram.sv
// rtl/sgdma_desc_ram.sv - descriptor table, one write port and one registered read port
//   clk_i                    clock
//   wr_en_i/wr_addr_i/wr_data_i  write port
//   rd_addr_i/rd_data_o      read port, data valid the cycle after the address
module sgdma_desc_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 55
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sgdma_desc_engine.sv
// rtl/sgdma_desc_engine.sv - descriptor table walker issuing DataMover MM2S commands
//   desc_wr_*        descriptor table write (IDLE only)
//   desc_count       entries per pass, ctrl_start/ctrl_stop/ctrl_loop run control
//   busy/done_irq    run status, err_* sticky error flags, cur_idx/pass_cnt progress
//   axis_cmd_*       DataMover command stream (registered)
//   axis_sts_*       DataMover status stream
module sgdma_desc_engine
  import sgdma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BTT_WIDTH       = 23,
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         axi_lite_reg_aclk,
  input  logic                         axi_lite_reg_aresetn,
  input  logic                         desc_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     desc_wr_idx,
  input  logic [ADDR_WIDTH-1:0]        desc_wr_addr,
  input  logic [BTT_WIDTH-1:0]         desc_wr_len,
  input  logic [$clog2(DEPTH):0]       desc_count,
  input  logic                         ctrl_start,
  input  logic                         ctrl_stop,
  input  logic                         ctrl_loop,
  output logic                         busy,
  output logic                         done_irq,
  output logic [2:0]                   err_sts,
  output logic                         err_tag,
  output logic                         err_cfg,
  output logic [$clog2(DEPTH)-1:0]     cur_idx,
  output logic [31:0]                  pass_cnt,
  output logic                         axis_cmd_tvalid,
  output logic [ADDR_WIDTH+40-1:0]     axis_cmd_tdata,
  input  logic                         axis_cmd_tready,
  input  logic                         axis_sts_tvalid,
  input  logic [7:0]                   axis_sts_tdata,
  input  logic                         axis_sts_tkeep,
  input  logic                         axis_sts_tlast,
  output logic                         axis_sts_tready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMD_W = ADDR_WIDTH + 40;
  localparam int ENT_W = ADDR_WIDTH + BTT_WIDTH;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);
  localparam logic [3:0]     MAX_OS  = 4'(MAX_OUTSTANDING);

  state_e           state_q;
  logic             loop_q;
  logic [IDX_W:0]   count_q;
  logic [IDX_W-1:0] cur_idx_q;
  logic [IDX_W-1:0] sts_idx_q;      // entry whose status is expected next
  logic [3:0]       issue_tag_q;
  logic [3:0]       exp_tag_q;
  logic [3:0]       outstanding_q;
  logic [3:0]       outstanding_d;
  logic             end_q;          // one-shot run has issued its last entry
  logic             rd_pend_q;      // table read in flight, data valid this cycle
  logic             cmd_valid_q;
  logic [CMD_W-1:0] cmd_data_q;
  logic [2:0]       err_sts_q;
  logic             err_tag_q;
  logic             err_cfg_q;
  logic [31:0]      pass_cnt_q;
  logic             done_q;

  logic [ENT_W-1:0]      rd_data;
  logic [BTT_WIDTH-1:0]  rd_len;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CMD_W-1:0]      new_cmd;
  logic [IDX_W:0]        last_full;
  logic [IDX_W-1:0]      last_idx;
  logic                  cmd_acc;
  logic                  sts_acc;
  logic                  can_read;
  logic                  pass_end;
  logic                  count_bad;
  logic [2:0]            sts_err;
  logic [3:0]            sts_tag;
  logic                  unused_sts;

  sgdma_desc_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk_i     (axi_lite_reg_aclk),
    .wr_en_i   (desc_wr_en && (state_q == ST_IDLE)),
    .wr_addr_i (desc_wr_idx),
    .wr_data_i ({desc_wr_addr, desc_wr_len}),
    .rd_addr_i (cur_idx_q),
    .rd_data_o (rd_data)
  );

  assign rd_len    = rd_data[BTT_WIDTH-1:0];
  assign rd_addr   = rd_data[ENT_W-1:BTT_WIDTH];
  assign last_full = count_q - 1'b1;
  assign last_idx  = last_full[IDX_W-1:0];
  assign cmd_acc   = cmd_valid_q && axis_cmd_tready;
  assign sts_acc   = axis_sts_tvalid && axis_sts_tready;
  assign pass_end  = sts_acc && (sts_idx_q == last_idx);
  assign count_bad = (desc_count == '0) || (desc_count > DEPTH_V);
  assign sts_err   = {axis_sts_tdata[STS_SLVERR_BIT], axis_sts_tdata[STS_DECERR_BIT],
                      axis_sts_tdata[STS_INTERR_BIT]};
  assign sts_tag   = axis_sts_tdata[STS_TAG_MSB:0];
  assign unused_sts = ^{axis_sts_tkeep, axis_sts_tlast, axis_sts_tdata[STS_OKAY_BIT]};

  // A read starts only with the command register empty and no read in flight,
  // so the outstanding count seen here is exact at the moment of issue.
  assign can_read = (state_q == ST_RUN) && !cmd_valid_q && !rd_pend_q && !end_q &&
                    (outstanding_q < MAX_OS);

  always_comb begin
    new_cmd = '0;
    new_cmd[BTT_WIDTH-1:0]                = rd_len;
    new_cmd[CMD_TYPE_BIT]                 = TYPE_INCR;
    new_cmd[CMD_EOF_BIT]                  = CMD_EOF;
    new_cmd[CMD_ADDR_LSB +: ADDR_WIDTH]   = rd_addr;
    new_cmd[CMD_ADDR_LSB+ADDR_WIDTH +: 4] = issue_tag_q;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (cmd_acc && !sts_acc) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!cmd_acc && sts_acc) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge axi_lite_reg_aclk or negedge axi_lite_reg_aresetn) begin
    if (!axi_lite_reg_aresetn) begin
      state_q       <= ST_IDLE;
      loop_q        <= 1'b0;
      count_q       <= '0;
      cur_idx_q     <= '0;
      sts_idx_q     <= '0;
      issue_tag_q   <= '0;
      exp_tag_q     <= '0;
      outstanding_q <= '0;
      end_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      err_sts_q     <= '0;
      err_tag_q     <= 1'b0;
      err_cfg_q     <= 1'b0;
      pass_cnt_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_start) begin
            if (count_bad) begin
              err_cfg_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              loop_q        <= ctrl_loop;
              count_q       <= desc_count;
              cur_idx_q     <= '0;
              sts_idx_q     <= '0;
              issue_tag_q   <= '0;
              exp_tag_q     <= '0;
              outstanding_q <= '0;
              end_q         <= 1'b0;
              cmd_valid_q   <= 1'b0;
              err_sts_q     <= '0;
              err_tag_q     <= 1'b0;
              err_cfg_q     <= 1'b0;
              pass_cnt_q    <= '0;
              state_q       <= ST_RUN;
            end
          end
        end
        default: begin
          outstanding_q <= outstanding_d;

          if (cmd_acc) begin
            cmd_valid_q <= 1'b0;
            issue_tag_q <= issue_tag_q + 4'd1;
            if (cur_idx_q == last_idx) begin
              cur_idx_q <= '0;
              if (!loop_q) begin
                end_q <= 1'b1;
              end
            end else begin
              cur_idx_q <= cur_idx_q + 1'b1;
            end
          end

          if (can_read) begin
            rd_pend_q <= 1'b1;
          end

          // A read that lands after a stop is simply dropped.
          if ((state_q == ST_RUN) && rd_pend_q && !ctrl_stop) begin
            if (rd_len == '0) begin
              err_cfg_q <= 1'b1;
              state_q   <= ST_DRAIN;
            end else begin
              cmd_data_q  <= new_cmd;
              cmd_valid_q <= 1'b1;
            end
          end

          if (sts_acc) begin
            exp_tag_q <= exp_tag_q + 4'd1;
            if (sts_tag != exp_tag_q) begin
              err_tag_q <= 1'b1;
            end
            err_sts_q <= err_sts_q | sts_err;
            if (pass_end) begin
              sts_idx_q <= '0;
              if (pass_cnt_q != '1) begin
                pass_cnt_q <= pass_cnt_q + 32'd1;
              end
            end else begin
              sts_idx_q <= sts_idx_q + 1'b1;
            end
          end

          if (state_q == ST_RUN) begin
            if (pass_end && !loop_q) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else if ((sts_acc && (sts_err != 3'b000)) || ctrl_stop) begin
              state_q <= ST_DRAIN;
            end
          end else if ((outstanding_q == 4'd0) && !cmd_valid_q) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done_irq        = done_q;
  assign err_sts         = err_sts_q;
  assign err_tag         = err_tag_q;
  assign err_cfg         = err_cfg_q;
  assign cur_idx         = cur_idx_q;
  assign pass_cnt        = pass_cnt_q;
  assign axis_cmd_tvalid = cmd_valid_q;
  assign axis_cmd_tdata  = cmd_data_q;
  assign axis_sts_tready = (state_q != ST_IDLE) && (outstanding_q != 4'd0);

endmodule

// File: tb/tb_sgdma_desc_engine.sv
// tb/tb_sgdma_desc_engine.sv - self-checking bench for sgdma_desc_engine
module tb_sgdma_desc_engine;

  localparam int AW = 32;
  localparam int BW = 23;
  localparam int DEPTH = 16;
  localparam int MAXO = 4;
  localparam int IW = 4;
  localparam int CW = 72;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          desc_wr_en;
  logic [IW-1:0] desc_wr_idx;
  logic [AW-1:0] desc_wr_addr;
  logic [BW-1:0] desc_wr_len;
  logic [IW:0]   desc_count;
  logic          ctrl_start, ctrl_stop, ctrl_loop;
  logic          busy, done_irq;
  logic [2:0]    err_sts;
  logic          err_tag, err_cfg;
  logic [IW-1:0] cur_idx;
  logic [31:0]   pass_cnt;
  logic          cmd_tvalid, cmd_tready;
  logic [CW-1:0] cmd_tdata;
  logic          sts_tvalid, sts_tkeep, sts_tlast, sts_tready;
  logic [7:0]    sts_tdata;

  sgdma_desc_engine #(
    .ADDR_WIDTH(AW), .BTT_WIDTH(BW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_lite_reg_aclk   (clk),
    .axi_lite_reg_aresetn(rst_n),
    .desc_wr_en          (desc_wr_en),
    .desc_wr_idx         (desc_wr_idx),
    .desc_wr_addr        (desc_wr_addr),
    .desc_wr_len         (desc_wr_len),
    .desc_count          (desc_count),
    .ctrl_start          (ctrl_start),
    .ctrl_stop           (ctrl_stop),
    .ctrl_loop           (ctrl_loop),
    .busy                (busy),
    .done_irq            (done_irq),
    .err_sts             (err_sts),
    .err_tag             (err_tag),
    .err_cfg             (err_cfg),
    .cur_idx             (cur_idx),
    .pass_cnt            (pass_cnt),
    .axis_cmd_tvalid     (cmd_tvalid),
    .axis_cmd_tdata      (cmd_tdata),
    .axis_cmd_tready     (cmd_tready),
    .axis_sts_tvalid     (sts_tvalid),
    .axis_sts_tdata      (sts_tdata),
    .axis_sts_tkeep      (sts_tkeep),
    .axis_sts_tlast      (sts_tlast),
    .axis_sts_tready     (sts_tready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [22:0] len;
    logic [71:0] cmd;
  } vec_t;

  vec_t vt [5];
  int n_chk = 0;
  int n_fail = 0;

  logic [71:0] cmd_log [$];
  int done_cnt = 0;

  always @(posedge clk) begin
    if (cmd_tvalid && cmd_tready) cmd_log.push_back(cmd_tdata);
    if (done_irq) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout, expected DUT event", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [31:0] a, input logic [22:0] l);
    desc_wr_en = 1'b1; desc_wr_idx = IW'(idx); desc_wr_addr = a; desc_wr_len = l;
    @(negedge clk);
    desc_wr_en = 1'b0;
  endtask

  task automatic start(input int cnt, input logic lp);
    desc_count = 5'(cnt); ctrl_loop = lp; ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_cmds(input int base, input int n);
    int k = 0;
    while ((cmd_log.size() - base < n) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) timeout("wait_cmds");
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while ((done_cnt == base) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) timeout("wait_done");
  endtask

  task automatic send_sts(input logic [7:0] d);
    bit ok = 1'b0;
    sts_tdata = d;
    sts_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (sts_tready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    sts_tvalid = 1'b0;
    if (!ok) timeout("send_sts");
  endtask

  task automatic serve(input int base, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      wait_cmds(base, i + 1);
      send_sts({4'h8, 4'(i)});
    end
  endtask

  initial begin
    int b, d, tot, served, k, bad;
    logic [71:0] exp_cmd;

    desc_wr_en = 0; desc_wr_idx = '0; desc_wr_addr = '0; desc_wr_len = '0;
    desc_count = '0; ctrl_start = 0; ctrl_stop = 0; ctrl_loop = 0;
    cmd_tready = 0; sts_tvalid = 0; sts_tdata = '0; sts_tkeep = 1; sts_tlast = 1;

    vt[0] = '{32'h0000_1000, 23'd64,       72'h00_00001000_40800040};
    vt[1] = '{32'h0000_2000, 23'd128,      72'h01_00002000_40800080};
    vt[2] = '{32'h0000_3000, 23'd4,        72'h02_00003000_40800004};
    vt[3] = '{32'hFFFF_FFFC, 23'h7F_FFFF,  72'h03_FFFFFFFC_40FFFFFF};
    vt[4] = '{32'h8000_0001, 23'd1,        72'h04_80000001_40800001};

    // reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_err_sts", err_sts, 0);
    chk("rst_err_tag", err_tag, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_cmd_tvalid", cmd_tvalid, 0);
    chk("rst_cmd_tdata", cmd_tdata, 0);
    chk("rst_sts_tready", sts_tready, 0);
    rst_n = 1'b1;
    tick(2);
    cmd_tready = 1'b1;

    for (int i = 0; i < 5; i++) wr(i, vt[i].addr, vt[i].len);

    // three-entry one-shot run
    b = cmd_log.size(); d = done_cnt;
    start(3, 1'b0);
    chk("t1_busy_run", busy, 1);
    serve(b, 0, 3);
    wait_done(d);
    tick(3);
    chk("t1_ncmd", cmd_log.size() - b, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_cmd%0d", i), cmd_log[b+i], vt[i].cmd);
    chk("t1_done_once", done_cnt - d, 1);
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_errs", {err_sts, err_tag, err_cfg}, 0);
    chk("t1_busy_end", busy, 0);

    // full vector table, including max BTT and top address
    b = cmd_log.size(); d = done_cnt;
    start(5, 1'b0);
    serve(b, 0, 5);
    wait_done(d);
    tick(3);
    for (int i = 0; i < 5; i++) chk($sformatf("t1b_cmd%0d", i), cmd_log[b+i], vt[i].cmd);
    chk("t1b_done_once", done_cnt - d, 1);

    // bad desc_count
    d = done_cnt;
    start(0, 1'b0);
    tick(2);
    chk("cfg0_err_cfg", err_cfg, 1);
    chk("cfg0_busy", busy, 0);
    chk("cfg0_done", done_cnt - d, 1);
    start(17, 1'b0);
    tick(2);
    chk("cfg17_busy", busy, 0);
    chk("cfg17_done", done_cnt - d, 2);

    // outstanding limit
    for (int i = 0; i < 8; i++) wr(i, 32'(32'h10000 + i * 256), 23'd16);
    b = cmd_log.size(); d = done_cnt;
    start(8, 1'b0);
    chk("t2_err_cfg_cleared", err_cfg, 0);
    tick(30);
    chk("t2_ncmd_max", cmd_log.size() - b, 4);
    chk("t2_tvalid_low", cmd_tvalid, 0);
    chk("t2_cur_idx", cur_idx, 4);
    send_sts(8'h80);
    tick(30);
    chk("t2_ncmd_one_more", cmd_log.size() - b, 5);
    chk("t2_tvalid_low2", cmd_tvalid, 0);
    serve(b, 1, 7);
    wait_done(d);
    tick(3);
    chk("t2_ncmd_all", cmd_log.size() - b, 8);
    chk("t2_done_once", done_cnt - d, 1);

    // SLVERR on entry 1
    b = cmd_log.size(); d = done_cnt;
    start(4, 1'b0);
    wait_cmds(b, 4);
    tick(5);
    send_sts(8'h80);
    send_sts(8'h41);
    tick(2);
    chk("t4_err_sts", err_sts, 3'b100);
    chk("t4_busy_drain", busy, 1);
    tick(10);
    chk("t4_no_more_cmds", cmd_log.size() - b, 4);
    send_sts(8'h82);
    send_sts(8'h83);
    wait_done(d);
    tick(3);
    chk("t4_busy_end", busy, 0);
    chk("t4_done_once", done_cnt - d, 1);
    chk("t4_err_sts_end", err_sts, 3'b100);
    chk("t4_err_tag", err_tag, 0);

    // stop while a command is presented
    cmd_tready = 1'b0;
    b = cmd_log.size(); d = done_cnt;
    start(8, 1'b0);
    tick(5);
    chk("t7_tvalid", cmd_tvalid, 1);
    chk("t7_tdata", cmd_tdata, 72'h00_00010000_40800010);
    ctrl_stop = 1'b1;
    tick(1);
    ctrl_stop = 1'b0;
    tick(3);
    chk("t7_tvalid_held", cmd_tvalid, 1);
    chk("t7_tdata_held", cmd_tdata, 72'h00_00010000_40800010);
    chk("t7_busy", busy, 1);
    cmd_tready = 1'b1;
    tick(10);
    chk("t7_ncmd", cmd_log.size() - b, 1);
    chk("t7_tvalid_low", cmd_tvalid, 0);
    send_sts(8'h80);
    wait_done(d);
    tick(2);
    chk("t7_busy_end", busy, 0);
    chk("t7_done_once", done_cnt - d, 1);

    // loop mode, 4 entries, 5 passes, tags cross 15 -> 0
    b = cmd_log.size(); d = done_cnt;
    start(4, 1'b1);
    serve(b, 0, 20);
    tick(1);
    chk("t3_pass5", pass_cnt, 5);
    chk("t3_busy", busy, 1);
    ctrl_stop = 1'b1;
    tick(1);
    ctrl_stop = 1'b0;
    served = 20; k = 0;
    while ((done_cnt == d) && (k < 400)) begin
      if (cmd_log.size() - b > served) begin
        send_sts({4'h8, 4'(served)});
        served++;
      end else begin
        @(negedge clk);
      end
      k++;
    end
    if (k >= 400) timeout("t3_drain");
    tick(3);
    tot = cmd_log.size() - b;
    chk("t3_all_served", served, tot);
    chk("t3_extra_bounded", ((tot - 20) <= MAXO) ? 1 : 0, 1);
    chk("t3_pass_final", pass_cnt, 32'(5 + (tot - 20) / 4));
    bad = 0;
    for (int i = 0; i < tot; i++) begin
      exp_cmd = {4'h0, 4'(i), 32'(32'h10000 + (i % 4) * 256), 32'h40800010};
      if (cmd_log[b+i] !== exp_cmd) bad++;
    end
    chk("t3_cmd_tags", bad, 0);
    chk("t3_done_once", done_cnt - d, 1);
    chk("t3_busy_end", busy, 0);

    // zero-length entry 2
    wr(2, 32'h10200, 23'd0);
    b = cmd_log.size(); d = done_cnt;
    start(4, 1'b0);
    tick(20);
    chk("t5_ncmd", cmd_log.size() - b, 2);
    chk("t5_err_cfg", err_cfg, 1);
    chk("t5_busy", busy, 1);
    chk("t5_no_done_yet", done_cnt - d, 0);
    serve(b, 0, 2);
    wait_done(d);
    tick(2);
    chk("t5_busy_end", busy, 0);
    chk("t5_done_once", done_cnt - d, 1);
    wr(2, 32'h10200, 23'd16);

    // tag mismatch, run continues
    b = cmd_log.size(); d = done_cnt;
    start(4, 1'b0);
    chk("t6_err_cfg_cleared", err_cfg, 0);
    wait_cmds(b, 1);
    send_sts(8'h85);
    tick(1);
    chk("t6_err_tag", err_tag, 1);
    chk("t6_busy", busy, 1);
    serve(b, 1, 3);
    wait_done(d);
    tick(2);
    chk("t6_pass", pass_cnt, 1);
    chk("t6_err_sts", err_sts, 0);
    chk("t6_done_once", done_cnt - d, 1);

    // asynchronous reset mid-run
    b = cmd_log.size(); d = done_cnt;
    start(4, 1'b1);
    wait_cmds(b, 2);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_tvalid", cmd_tvalid, 0);
    chk("rr_tdata", cmd_tdata, 0);
    chk("rr_sts_tready", sts_tready, 0);
    chk("rr_cur_idx", cur_idx, 0);
    chk("rr_pass", pass_cnt, 0);
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("rr_no_done", done_cnt - d, 0);
    chk("rr_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
